// File: rtl/cpu_bus_if.sv
// rtl/cpu_bus_if.sv - M-cycle bus engine: T1..T4 sequencing, wait states, register file write-back
//
// Ports:
//   clk, rst_n                        clock (one T-state per rising edge), async active-low reset
//   req_valid/req_ready               request handshake, ready in IDLE and T4 only
//   req_we, req_addr, req_wdata       access direction, address, write byte
//   req_dst                           byte register receiving read data
//   req_idu_op, req_idu_reg           address inc/dec op and the pair that receives it
//   bus_addr, bus_wdata, bus_rdata    external bus
//   bus_rd, bus_wr, bus_wait          strobes and slave stretch
//   rf_write_r, rf_reg_r, rf_data_r   byte register write port (pulse in T4)
//   rf_write_rr, rf_reg_rr, rf_data_rr pair register write port (pulse in T4)
//   mcycle_done                       pulse in T4
//   bus_err                           pulse in T4 after a wait timeout
//
// Optional feature: BUS_TIMEOUT_EN enables the T3 wait counter and bus_err.

package cpu_bus_pkg;
    typedef enum logic [2:0] {
        REG_A, REG_F, REG_B, REG_C, REG_D, REG_E, REG_H, REG_L
    } register_n_t;

    typedef enum logic [2:0] {
        REG_AF, REG_BC, REG_DE, REG_HL, REG_SP, REG_PC
    } register_nn_t;
endpackage

module cpu_bus_if
    import cpu_bus_pkg::*;
#(
    parameter int WAIT_MAX = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [15:0]  req_addr,
    input  logic [7:0]   req_wdata,
    input  register_n_t  req_dst,
    input  logic [1:0]   req_idu_op,
    input  register_nn_t req_idu_reg,
    output logic [15:0]  bus_addr,
    output logic [7:0]   bus_wdata,
    input  logic [7:0]   bus_rdata,
    output logic         bus_rd,
    output logic         bus_wr,
    input  logic         bus_wait,
    output logic         rf_write_r,
    output register_n_t  rf_reg_r,
    output logic [7:0]   rf_data_r,
    output logic         rf_write_rr,
    output register_nn_t rf_reg_rr,
    output logic [15:0]  rf_data_rr,
    output logic         mcycle_done,
    output logic         bus_err
);

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_T4} state_t;

    state_t       state_q;
    logic         we_q;
    logic [15:0]  addr_q;
    logic [7:0]   wdata_q;
    register_n_t  dst_q;
    logic [1:0]   idu_op_q;
    register_nn_t idu_reg_q;

    logic         hs;
    logic [15:0]  idu_d;
    logic         t3_done_d;
    logic [7:0]   t3_data_d;
    logic         t3_err_d;

    assign hs = req_valid & req_ready;

    // Only 01 and 10 touch the pair; 11 behaves like 00.
    always_comb begin
        idu_d = addr_q;
        case (idu_op_q)
            2'b01:   idu_d = addr_q + 16'd1;
            2'b10:   idu_d = addr_q - 16'd1;
            default: idu_d = addr_q;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    localparam int WCNT_W = $clog2(WAIT_MAX + 1);
    logic [WCNT_W-1:0] wait_cnt_q;

    // The WAIT_MAX-th consecutive wait cycle ends T3 with forced 0xFF data.
    always_comb begin
        t3_done_d = 1'b0;
        t3_data_d = bus_rdata;
        t3_err_d  = 1'b0;
        if (!bus_wait) begin
            t3_done_d = 1'b1;
        end else if (wait_cnt_q == WCNT_W'(WAIT_MAX - 1)) begin
            t3_done_d = 1'b1;
            t3_data_d = 8'hFF;
            t3_err_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if (hs) begin
            wait_cnt_q <= '0;
        end else if (state_q == S_T3 && bus_wait && !t3_done_d) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end
`else
    always_comb begin
        t3_done_d = ~bus_wait;
        t3_data_d = bus_rdata;
        t3_err_d  = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            dst_q       <= REG_A;
            idu_op_q    <= '0;
            idu_reg_q   <= REG_AF;
            req_ready   <= 1'b1;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_rd      <= 1'b0;
            bus_wr      <= 1'b0;
            rf_write_r  <= 1'b0;
            rf_reg_r    <= REG_A;
            rf_data_r   <= '0;
            rf_write_rr <= 1'b0;
            rf_reg_rr   <= REG_AF;
            rf_data_rr  <= '0;
            mcycle_done <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            rf_write_r  <= 1'b0;
            rf_write_rr <= 1'b0;
            mcycle_done <= 1'b0;
            bus_err     <= 1'b0;
            case (state_q)
                S_IDLE, S_T4: begin
                    bus_wdata <= '0;
                    if (hs) begin
                        we_q      <= req_we;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        dst_q     <= req_dst;
                        idu_op_q  <= req_idu_op;
                        idu_reg_q <= req_idu_reg;
                        bus_addr  <= req_addr;
                        req_ready <= 1'b0;
                        state_q   <= S_T1;
                    end else begin
                        bus_addr  <= '0;
                        req_ready <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                S_T1: begin
                    bus_rd  <= ~we_q;
                    bus_wr  <= we_q;
                    if (we_q) begin
                        bus_wdata <= wdata_q;
                    end
                    state_q <= S_T2;
                end
                S_T2: begin
                    state_q <= S_T3;
                end
                S_T3: begin
                    if (t3_done_d) begin
                        bus_rd      <= 1'b0;
                        bus_wr      <= 1'b0;
                        req_ready   <= 1'b1;
                        mcycle_done <= 1'b1;
                        bus_err     <= t3_err_d;
                        rf_write_r  <= ~we_q;
                        rf_reg_r    <= dst_q;
                        rf_data_r   <= t3_data_d;
                        if (idu_op_q == 2'b01 || idu_op_q == 2'b10) begin
                            rf_write_rr <= 1'b1;
                            rf_reg_rr   <= idu_reg_q;
                            rf_data_rr  <= idu_d;
                        end
                        state_q     <= S_T4;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
